nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/nibble_serial_adder_adder.sv | 15 +
 rtl/nibble_serial_adder.sv | 115 +++++++++++
 tb/tb_nibble_serial_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_adder.sv
// Combinational 4-bit add with carry in/out; the single adder shared by every step.
module nibble_adder
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_ci,
  output logic [NIB_W-1:0] o_sum,
  output logic             o_co
);

  // Widen before adding so the carry is taken from a full-width result.
  assign {o_co, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{NIB_W{1'b0}}, i_ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// W-bit adder processing one nibble per clock, LSB first, with start/busy/done handshake.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 overflow
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           r_state;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_res_sh;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [W-1:0]     r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [NIB_W-1:0] w_nib;
  logic             w_cy;
  logic [W-1:0]     w_res_next;

  nibble_adder u_nibble_adder (
    .i_a   (r_a_sh[NIB_W-1:0]),
    .i_b   (r_b_sh[NIB_W-1:0]),
    .i_ci  (r_carry),
    .o_sum (w_nib),
    .o_co  (w_cy)
  );

  // New nibble enters at the top; after NIBBLES steps the LSB nibble has reached bit 0.
  assign w_res_next = (r_res_sh >> NIB_W) | (W'(w_nib) << (W - NIB_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_sum    <= '0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state  <= ST_RUN;
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_a_msb  <= a[W-1];
            r_b_msb  <= b[W-1];
            r_carry  <= c_in;
            r_res_sh <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_res_sh <= w_res_next;
          r_a_sh   <= r_a_sh >> NIB_W;
          r_b_sh   <= r_b_sh >> NIB_W;
          r_carry  <= w_cy;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
            r_sum   <= w_res_next;
            r_c_out <= w_cy;
            r_ovf   <= (r_a_msb == r_b_msb) && (w_res_next[W-1] != r_a_msb);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at NIBBLES=4 and NIBBLES=1.
module tb_nibble_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start4 = 1'b0, ci4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        busy4, done4, cout4, ovf4;
  logic [15:0] sum4;

  logic        start1 = 1'b0, ci1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, cout1, ovf1;
  logic [3:0]  sum1;

  int tests = 0;
  int fails = 0;
  exp_t q4[$];
  exp_t q1[$];
  logic [15:0] held4 = '0;
  logic [3:0]  held1 = '0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .c_in(ci4),
    .busy(busy4), .done(done4), .sum(sum4), .c_out(cout4), .overflow(ovf4)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .overflow(ovf1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic on the whole operands.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci);
    logic [16:0] full;
    logic [15:0] mask;
    exp_t e;
    mask   = (w == 16) ? 16'hFFFF : ((16'h1 << w) - 16'h1);
    full   = {1'b0, a & mask} + {1'b0, b & mask} + {16'h0, ci};
    e.s    = full[15:0] & mask;
    e.c    = full[w];
    e.o    = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("done4_unexpected", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        check("sum4", {16'h0, sum4}, {16'h0, e.s});
        check("cout4", {31'h0, cout4}, {31'h0, e.c});
        check("ovf4", {31'h0, ovf4}, {31'h0, e.o});
        check("busy4_in_done", {31'h0, busy4}, 32'd0);
        held4 = e.s;
      end
    end
    if (!rst && busy4) check("sum4_stable", {16'h0, sum4}, {16'h0, held4});
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done1) begin
      if (q1.size() == 0) begin
        check("done1_unexpected", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("sum1", {28'h0, sum1}, {28'h0, e.s[3:0]});
        check("cout1", {31'h0, cout1}, {31'h0, e.c});
        check("ovf1", {31'h0, ovf1}, {31'h0, e.o});
        held1 = e.s[3:0];
      end
    end
    if (!rst && busy1) check("sum1_stable", {28'h0, sum1}, {28'h0, held1});
  end

  // Called #1 after an edge with the DUT idle or in its done cycle; returns in the done cycle.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic ci);
    int n;
    a4 = a; b4 = b; ci4 = ci; start4 = 1'b1;
    q4.push_back(model(16, a, b, ci));
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = ~a; b4 = ~b; ci4 = ~ci;
    n = 0;
    while (busy4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy4_cycles", n, 32'd4);
    check("done4_after_busy", {31'h0, done4}, 32'd1);
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int n;
    a1 = a; b1 = b; ci1 = ci; start1 = 1'b1;
    q1.push_back(model(4, {12'h0, a}, {12'h0, b}, ci));
    @(posedge clk); #1;
    start1 = 1'b0;
    n = 0;
    while (busy1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy1_cycles", n, 32'd1);
    check("done1_after_busy", {31'h0, done1}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy", {31'h0, busy4}, 32'd0);
    check("rst_done", {31'h0, done4}, 32'd0);
    check("rst_sum", {16'h0, sum4}, 32'd0);
    check("rst_cout_ovf", {30'h0, cout4, ovf4}, 32'd0);

    op4(16'h1234, 16'h0FFF, 1'b0); @(posedge clk); #1;
    op4(16'hFFFF, 16'h0000, 1'b1); @(posedge clk); #1;
    op4(16'h7FFF, 16'h0001, 1'b0); @(posedge clk); #1;
    op4(16'h8000, 16'h8000, 1'b0); @(posedge clk); #1;

    op1(4'b1001, 4'b0111, 1'b1); @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      op1(4'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;

    // Start pulsed mid-RUN with other operands must be ignored.
    a4 = 16'h0102; b4 = 16'h0304; ci4 = 1'b0; start4 = 1'b1;
    q4.push_back(model(16, 16'h0102, 16'h0304, 1'b0));
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    a4 = 16'hAAAA; b4 = 16'h5555; ci4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    for (int n = 0; n < 20 && !done4; n++) begin @(posedge clk); #1; end
    check("ignored_start_done", {31'h0, done4}, 32'd1);
    @(posedge clk); #1;
    check("ignored_start_not_queued", {31'h0, busy4}, 32'd0);

    // Back-to-back: second start issued in the done cycle.
    op4(16'h1111, 16'h2222, 1'b0);
    op4(16'hF0F0, 16'h0F10, 1'b0);
    @(posedge clk); #1;

    // Reset during the second RUN cycle discards the operation.
    a4 = 16'h4321; b4 = 16'h1111; ci4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    held4 = '0;
    check("midrst_busy", {31'h0, busy4}, 32'd0);
    check("midrst_done", {31'h0, done4}, 32'd0);
    check("midrst_sum", {16'h0, sum4}, 32'd0);
    check("midrst_cout_ovf", {30'h0, cout4, ovf4}, 32'd0);
    op4(16'h4321, 16'h1111, 1'b1); @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      op4(16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("q4_drained", q4.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
